// File: rtl/vdp_port.sv
// CPU-side port front end of a TMS9918-style VDP: register file, VRAM port A access,
// status flags and interrupt generation, all in the CPU clock domain.
module vdp_port (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_mode,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        busy,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        vram_wr,
  output logic        vram_rd,
  input  logic [7:0]  vram_din,
  input  logic        frame_int,
  input  logic        coll_in,
  input  logic        fifth_in,
  input  logic [4:0]  fifth_num,
  output logic [1:0]  mode,
  output logic        video_on,
  output logic        vert_retrace_int,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic        n_int
);

  typedef enum logic [1:0] {StIdle, StFetch, StCapture} ra_state_e;

  ra_state_e   state_q, state_d;
  logic [7:0]  regs_q [8];
  logic [7:0]  latch_q, rbuf_q, cpu_dout_q, vram_dout_q;
  logic [13:0] addr_q, vram_addr_q;
  logic [4:0]  num_q;
  logic        f_q, s5_q, c_q, second_q, vram_wr_q;

  logic take_wr, take_rd, ctl_wr, data_wr, stat_rd, data_rd, set_addr, start_ra;

  // Strobes are dropped while a read-ahead owns the address; write beats read.
  always_comb begin
    take_wr  = cpu_wr & ~busy;
    take_rd  = cpu_rd & ~cpu_wr & ~busy;
    ctl_wr   = take_wr & cpu_mode;
    data_wr  = take_wr & ~cpu_mode;
    stat_rd  = take_rd & cpu_mode;
    data_rd  = take_rd & ~cpu_mode;
    set_addr = ctl_wr & second_q & ~cpu_din[7];
    start_ra = data_rd | (set_addr & ~cpu_din[6]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_ra) state_d = StFetch;
      StFetch:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      latch_q     <= '0;
      rbuf_q      <= '0;
      cpu_dout_q  <= '0;
      vram_dout_q <= '0;
      addr_q      <= '0;
      vram_addr_q <= '0;
      num_q       <= '0;
      f_q         <= 1'b0;
      s5_q        <= 1'b0;
      c_q         <= 1'b0;
      second_q    <= 1'b0;
      vram_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vram_wr_q <= data_wr;

      if (ctl_wr) begin
        if (!second_q) begin
          latch_q  <= cpu_din;
          second_q <= 1'b1;
        end else begin
          second_q <= 1'b0;
          if (cpu_din[7]) begin
            regs_q[cpu_din[2:0]] <= latch_q;
          end else begin
            addr_q      <= {cpu_din[5:0], latch_q};
            vram_addr_q <= {cpu_din[5:0], latch_q};
          end
        end
      end

      if (data_wr) begin
        vram_dout_q <= cpu_din;
        vram_addr_q <= addr_q;
        rbuf_q      <= cpu_din;
        addr_q      <= addr_q + 14'd1;
        second_q    <= 1'b0;
      end

      if (data_rd) begin
        cpu_dout_q  <= rbuf_q;
        vram_addr_q <= addr_q;
        second_q    <= 1'b0;
      end

      if (stat_rd) begin
        cpu_dout_q <= {f_q, s5_q, c_q, num_q};
        second_q   <= 1'b0;
      end

      // VRAM data lands the cycle after the read strobe.
      if (state_q == StCapture) begin
        rbuf_q <= vram_din;
        addr_q <= addr_q + 14'd1;
      end

      // A set event in the same cycle as a status read keeps the flag set.
      f_q  <= (f_q & ~stat_rd) | frame_int;
      c_q  <= (c_q & ~stat_rd) | coll_in;
      s5_q <= (s5_q & ~stat_rd) | fifth_in;
      if (fifth_in && !s5_q) num_q <= fifth_num;
    end
  end

  always_comb begin
    if (regs_q[1][4])      mode = 2'd0;
    else if (regs_q[0][1]) mode = 2'd2;
    else if (regs_q[1][3]) mode = 2'd3;
    else                   mode = 2'd1;
  end

  assign cpu_dout                  = cpu_dout_q;
  assign busy                      = (state_q != StIdle);
  assign vram_addr                 = vram_addr_q;
  assign vram_dout                 = vram_dout_q;
  assign vram_wr                   = vram_wr_q;
  assign vram_rd                   = (state_q == StFetch);
  assign video_on                  = regs_q[1][6];
  assign vert_retrace_int          = regs_q[1][5];
  assign sprite_large              = regs_q[1][1];
  assign sprite_enlarged           = regs_q[1][0];
  assign name_table_addr           = {regs_q[2][3:0], 10'b0};
  assign color_table_addr          = {regs_q[3], 6'b0};
  assign font_addr                 = {regs_q[4][2:0], 11'b0};
  assign sprite_attr_addr          = {regs_q[5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {regs_q[6][2:0], 11'b0};
  assign text_color                = regs_q[7][7:4];
  assign back_color                = regs_q[7][3:0];
  assign n_int                     = ~(f_q & regs_q[1][5]);

  logic unused_bits;
  assign unused_bits = ^{regs_q[0][7:2], regs_q[0][0], regs_q[1][7], regs_q[1][2],
                         regs_q[2][7:4], regs_q[4][7:3], regs_q[5][7], regs_q[6][7:3]};

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port: register writes, VRAM write/read-ahead with wrap,
// status flags, interrupt and control byte-pair resynchronisation.
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        n_reset, cpu_mode, cpu_wr, cpu_rd;
  logic [7:0]  cpu_din, cpu_dout, vram_dout, vram_din;
  logic        busy, vram_wr, vram_rd;
  logic [13:0] vram_addr;
  logic        frame_int, coll_in, fifth_in;
  logic [4:0]  fifth_num;
  logic [1:0]  mode;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [13:0] name_table_addr, color_table_addr, font_addr, sprite_attr_addr;
  logic [13:0] sprite_pattern_table_addr;
  logic [3:0]  text_color, back_color;
  logic        n_int;

  int checks = 0;
  int errors = 0;
  int rd_seen = 0;

  always #5 clk = ~clk;

  vdp_port dut (
    .clk                       (clk),
    .n_reset                   (n_reset),
    .cpu_mode                  (cpu_mode),
    .cpu_wr                    (cpu_wr),
    .cpu_rd                    (cpu_rd),
    .cpu_din                   (cpu_din),
    .cpu_dout                  (cpu_dout),
    .busy                      (busy),
    .vram_addr                 (vram_addr),
    .vram_dout                 (vram_dout),
    .vram_wr                   (vram_wr),
    .vram_rd                   (vram_rd),
    .vram_din                  (vram_din),
    .frame_int                 (frame_int),
    .coll_in                   (coll_in),
    .fifth_in                  (fifth_in),
    .fifth_num                 (fifth_num),
    .mode                      (mode),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .text_color                (text_color),
    .back_color                (back_color),
    .n_int                     (n_int)
  );

  // VRAM model: contents are addr[7:0] ^ 0xA5, data valid the cycle after vram_rd.
  always @(posedge clk) if (vram_rd) vram_din <= vram_addr[7:0] ^ 8'hA5;
  always @(negedge clk) if (vram_rd) rd_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each strobe returns at the negedge of cycle N+1.
  task automatic ctl_wr(input logic [7:0] d);
    cpu_mode = 1'b1; cpu_din = d; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] d);
    cpu_mode = 1'b0; cpu_din = d; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic rd(input logic port);
    cpu_mode = port; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  initial begin
    n_reset = 1'b0; cpu_mode = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = 8'h00;
    vram_din = 8'h00; frame_int = 1'b0; coll_in = 1'b0; fifth_in = 1'b0; fifth_num = 5'd0;
    idle(2);
    check("rst_mode", mode, 2'd1);
    check("rst_n_int", n_int, 1'b1);
    check("rst_vram_addr", vram_addr, 14'h0000);
    check("rst_video_on", video_on, 1'b0);
    check("rst_cpu_dout", cpu_dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    n_reset = 1'b1;
    idle(1);

    // Register writes
    ctl_wr(8'hF4); idle(2); ctl_wr(8'h87);
    check("r7_text", text_color, 4'hF);
    check("r7_back", back_color, 4'h4);
    idle(2);
    ctl_wr(8'hF0); idle(2); ctl_wr(8'h81);
    check("r1_video_on", video_on, 1'b1);
    check("r1_ie", vert_retrace_int, 1'b1);
    check("r1_mode_text", mode, 2'd0);
    idle(2);
    ctl_wr(8'h02); idle(2); ctl_wr(8'h80); idle(2);
    ctl_wr(8'hE0); idle(2); ctl_wr(8'h81);
    check("mode_g2", mode, 2'd2);
    idle(2);
    ctl_wr(8'h0E); idle(2); ctl_wr(8'h82);
    check("name_table", name_table_addr, 14'h3800);
    idle(2);
    ctl_wr(8'hFF); idle(2); ctl_wr(8'h83);
    check("color_table", color_table_addr, 14'h3FC0);
    idle(2);

    // VRAM writes
    rd_seen = 0;
    ctl_wr(8'h00); idle(2); ctl_wr(8'h78); idle(2);
    data_wr(8'h11);
    check("wr0_strobe", vram_wr, 1'b1);
    check("wr0_addr", vram_addr, 14'h3800);
    check("wr0_data", vram_dout, 8'h11);
    idle(1);
    check("wr0_pulse_end", vram_wr, 1'b0);
    idle(2);
    data_wr(8'h22);
    check("wr1_addr", vram_addr, 14'h3801);
    check("wr1_data", vram_dout, 8'h22);
    idle(3);
    data_wr(8'h33);
    check("wr2_addr", vram_addr, 14'h3802);
    check("wr2_data", vram_dout, 8'h33);
    idle(3);
    check("wr_no_rd", rd_seen, 0);

    // Read-ahead at 0x3FFF, then wrap to 0x0000
    ctl_wr(8'hFF); idle(2); ctl_wr(8'h3F);
    check("ra_rd", vram_rd, 1'b1);
    check("ra_addr", vram_addr, 14'h3FFF);
    check("ra_busy1", busy, 1'b1);
    idle(1);
    check("ra_busy2", busy, 1'b1);
    check("ra_rd_end", vram_rd, 1'b0);
    idle(1);
    check("ra_busy_end", busy, 1'b0);
    idle(1);
    rd(1'b0);
    check("dr_data", cpu_dout, 8'h5A);
    check("dr_rd", vram_rd, 1'b1);
    check("dr_wrap_addr", vram_addr, 14'h0000);
    // Write during busy is dropped
    data_wr(8'h77);
    check("busy_drop", vram_wr, 1'b0);
    idle(3);
    rd(1'b0);
    check("dr2_data", cpu_dout, 8'hA5);
    check("dr2_addr", vram_addr, 14'h0001);
    idle(3);

    // Simultaneous write and read: write wins
    rd_seen = 0;
    cpu_mode = 1'b0; cpu_din = 8'h5C; cpu_wr = 1'b1; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    check("wr_rd_wr", vram_wr, 1'b1);
    check("wr_rd_data", vram_dout, 8'h5C);
    idle(3);
    check("wr_rd_no_rd", rd_seen, 0);

    // Interrupt and status
    frame_int = 1'b1; @(negedge clk); frame_int = 1'b0;
    check("int_low", n_int, 1'b0);
    idle(2);
    rd(1'b1);
    check("stat_f", cpu_dout, 8'h80);
    check("int_release", n_int, 1'b1);
    idle(2);
    frame_int = 1'b1; cpu_mode = 1'b1; cpu_rd = 1'b1;
    @(negedge clk);
    frame_int = 1'b0; cpu_rd = 1'b0;
    check("stat_coincide", cpu_dout, 8'h00);
    check("coincide_f_kept", n_int, 1'b0);
    idle(2);
    rd(1'b1);
    check("stat_f_again", cpu_dout, 8'h80);
    idle(2);
    fifth_in = 1'b1; fifth_num = 5'h0B; @(negedge clk);
    fifth_num = 5'h05; @(negedge clk);
    fifth_in = 1'b0;
    idle(1);
    rd(1'b1);
    check("stat_5s", cpu_dout, 8'h4B);
    idle(2);
    coll_in = 1'b1; @(negedge clk); coll_in = 1'b0;
    idle(1);
    rd(1'b1);
    check("stat_coll", cpu_dout, 8'h2B);
    idle(2);
    frame_int = 1'b1; @(negedge clk); frame_int = 1'b0;
    check("int_low2", n_int, 1'b0);
    ctl_wr(8'hC0); idle(2); ctl_wr(8'h81);
    check("ie_off_release", n_int, 1'b1);
    idle(2);
    ctl_wr(8'hE0); idle(2); ctl_wr(8'h81);
    check("ie_on_f_kept", n_int, 1'b0);
    idle(2);

    // Byte-pair resync via status read
    ctl_wr(8'h12); idle(2);
    rd(1'b1); idle(2);
    ctl_wr(8'h34); idle(2); ctl_wr(8'h40);
    check("resync_addr", vram_addr, 14'h0034);
    check("resync_text", text_color, 4'hF);
    check("resync_back", back_color, 4'h4);
    check("resync_mode", mode, 2'd2);
    check("resync_no_ra", busy, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vdp_port.md
# vdp_port

CPU-side register and port front end of the MSX VDP (TMS9918-style), clocked in the CPU domain. It decodes data-port and control-port strobes from the Z80 bus and keeps the VDP registers R0–R7. It drives the VRAM port A signals (address, data, write/read strobes) that feed the `video` block, along with every configuration input that block consumes (mode, table bases, colours, sprite size/magnify). It also holds the status register and generates the CPU interrupt.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: CPU clock (same clock as VRAM port A).
- `n_reset` in 1: synchronous, active-low reset.
- `cpu_mode` in 1: port select; 0 = data port (0x98), 1 = control/status port (0x99).
- `cpu_wr` in 1: one-cycle write strobe, port already decoded.
- `cpu_rd` in 1: one-cycle read strobe, port already decoded.
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: CPU read data, registered.
- `busy` out 1: read-ahead in progress; strobes are ignored while high.
- `vram_addr` out 14: VRAM address.
- `vram_dout` out 8: VRAM write data.
- `vram_wr` out 1: one-cycle VRAM write strobe.
- `vram_rd` out 1: one-cycle VRAM read strobe.
- `vram_din` in 8: VRAM read data, valid the cycle after `vram_rd`.
- `frame_int` in 1: one-cycle pulse at the start of vertical blank.
- `coll_in` in 1: sprite collision pulse or level.
- `fifth_in` in 1: fifth-sprite flag.
- `fifth_num` in 5: sprite number reported with `fifth_in`.
- `mode` out 2: 0 text, 1 graphics I, 2 graphics II, 3 multicolour.
- `video_on` out 1: R1[6].
- `vert_retrace_int` out 1: R1[5] (IE).
- `sprite_large` out 1: R1[1].
- `sprite_enlarged` out 1: R1[0].
- `name_table_addr` out 14: {R2[3:0], 10'b0}.
- `color_table_addr` out 14: {R3, 6'b0}.
- `font_addr` out 14: {R4[2:0], 11'b0}.
- `sprite_attr_addr` out 14: {R5[6:0], 7'b0}.
- `sprite_pattern_table_addr` out 14: {R6[2:0], 11'b0}.
- `text_color` out 4: R7[7:4].
- `back_color` out 4: R7[3:0].
- `n_int` out 1: active-low CPU interrupt.

## Operation
- Mode decode uses M1 = R1[4], M2 = R1[3], M3 = R0[1], with priority M1 > M3 > M2:
  - M1 → 0
  - M3 → 2
  - M2 → 3
  - otherwise → 1
- Control write, first byte: `latch <= cpu_din`, `second <= 1`.
- Control write, second byte (`second = 1`); `second <= 0` in every case:
  - `cpu_din[7] = 1`: register write, `R[cpu_din[2:0]] <= latch`; bits 6:3 are ignored.
  - `cpu_din[7] = 0`: `addr <= {cpu_din[5:0], latch}`.
  - If additionally `cpu_din[6] = 0`, start a read-ahead at the new address.
- Data write: `vram_dout <= cpu_din`, `vram_wr` pulses at `addr`, `rbuf <= cpu_din`, `addr <= addr+1`, `second <= 0`.
- Data read: `cpu_dout <= rbuf`, `second <= 0`, then start a read-ahead.
- Read-ahead state machine:
  - IDLE → FETCH: `vram_rd = 1` at `addr`.
  - FETCH → CAPTURE: `rbuf <= vram_din`, `addr <= addr+1`.
  - CAPTURE → IDLE.
  - `busy` is high in FETCH and CAPTURE.
- Status read: `cpu_dout <= {F, 5S, C, num[4:0]}`; then clear F, 5S and C; `second <= 0`.
- Status flag setting:
  - F is set by `frame_int`.
  - C is set by `coll_in`.
  - 5S is set by `fifth_in`; `num <= fifth_num` only while 5S = 0.
  - A set event coinciding with a status read wins: the flag stays set, and the read returns the old value.
- `n_int = !(F & R1[5])`. Clearing IE releases `n_int` without clearing F.
- Address arithmetic is 14-bit and wraps 0x3FFF → 0x0000.
- A strobe arriving while `busy = 1` is dropped with no state change.
- Simultaneous `cpu_wr` and `cpu_rd`: the write is taken and the read is ignored.

## Timing
- Reset values:
  - All of R0–R7, `latch`, `addr`, `rbuf`, `num`, F, 5S, C and `second` are 0.
  - Outputs: `cpu_dout` = 0, `vram_*` = 0, `busy` = 0, `n_int` = 1, `mode` = 1, all table bases 0, colours 0.
  - Reset mid-read-ahead returns the state machine to IDLE with no capture.
- Strobe in cycle N:
  - `cpu_dout`, register outputs, `addr`, `vram_wr` and `vram_dout` are valid in cycle N+1.
  - `vram_wr` is high for N+1 only.
- Read-ahead started by a strobe in cycle N:
  - `vram_rd` is high in N+1; `rbuf` is updated and `addr` incremented at the end of N+2.
  - `busy` is high in N+1..N+2.
- `frame_int` in cycle N: F = 1 and `n_int` low from N+1.
- The CPU bus guarantees at least 3 cycles between strobes; `busy` covers any violation of this.

## Test plan
- Reset: assert `n_reset` = 0 for 2 cycles → `mode` = 1, `n_int` = 1, `vram_addr` = 0, `video_on` = 0, `cpu_dout` = 0x00.
- Register write: control writes 0xF4, 0x87 → `text_color` = F, `back_color` = 4. Then 0xF0, 0x81 → `video_on` = 1, IE = 1, `mode` = 0. Then 0x02, 0x80 plus 0xE0, 0x81 → `mode` = 2.
- VRAM write: control 0x00, 0x78; data writes 0x11, 0x22, 0x33 → `vram_wr` pulses at 0x3800, 0x3801, 0x3802 with those data; no `vram_rd`.
- Read-ahead and wrap: control 0xFF, 0x3F with `vram_din` model → `vram_rd` at 0x3FFF. A data read returns that byte, and the next `vram_rd` is at 0x0000.
- Interrupt:
  - With IE = 1, pulse `frame_int` → `n_int` = 0.
  - Status read → `cpu_dout[7]` = 1 and `n_int` = 1 next cycle.
  - `frame_int` coincident with a status read → `cpu_dout[7]` = 0 and F stays set.
- Byte-pair resync: control write 0x12, then status read, then control write 0x34, 0x40 → `addr` = 0x0034, so 0x34 is treated as a first byte and no register changes.
